// File: rtl/hazard3_timer_sched_pkg.sv
// Shared types and constants for the mtimecmp deadline scheduler.
package hazard3_timer_sched_pkg;

   localparam int unsigned DL_W       = 64;
   localparam int unsigned SETTLE_LEN = 2;
   localparam int unsigned SETTLE_W   = 2;
   localparam logic [DL_W-1:0] CMP_DISABLE = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      ST_RESET_PROG = 3'd0,
      ST_CALC       = 3'd1,
      ST_WR_LO_MAX  = 3'd2,
      ST_WR_HI      = 3'd3,
      ST_WR_LO      = 3'd4,
      ST_SETTLE     = 3'd5,
      ST_WAIT       = 3'd6,
      ST_EXPIRE     = 3'd7
   } state_e;

   typedef struct packed {
      logic [15:0] addr;
      logic [31:0] data;
   } apb_wr_t;

endpackage

// File: rtl/hazard3_timer_sched_min.sv
// Combinational earliest-deadline finder; ties resolve to the lowest index.
module hazard3_timer_sched_min
   import hazard3_timer_sched_pkg::*;
#(
   parameter int unsigned N_SLOTS = 4
)(
   input  logic [N_SLOTS-1:0]           i_armed,
   input  logic [N_SLOTS-1:0][DL_W-1:0] i_deadline,
   output logic [DL_W-1:0]              o_min_c,
   output logic                         o_none_armed_c
);

   always_comb begin
      o_min_c        = CMP_DISABLE;
      o_none_armed_c = 1'b1;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         if (i_armed[i] && (o_none_armed_c || (i_deadline[i] < o_min_c))) begin
            o_min_c        = i_deadline[i];
            o_none_armed_c = 1'b0;
         end
      end
   end

endmodule

// File: rtl/hazard3_timer_sched.sv
// Multiplexes N_SLOTS deadlines onto one mtimecmp over APB, firing expired slots.
// mtimecmp is raised to all-ones before the high word changes so it never dips below target.
module hazard3_timer_sched
   import hazard3_timer_sched_pkg::*;
#(
   parameter int unsigned N_SLOTS     = 4,
   parameter logic [15:0] CMP_LO_ADDR = 16'h0010,
   parameter logic [15:0] CMP_HI_ADDR = 16'h0014
)(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       slot_wen,
   input  logic                       slot_clr,
   input  logic [$clog2(N_SLOTS)-1:0] slot_idx,
   input  logic [63:0]                slot_deadline,
   output logic [N_SLOTS-1:0]         armed,
   output logic [N_SLOTS-1:0]         fire,
   output logic                       busy,
   output logic [15:0]                paddr,
   output logic                       psel,
   output logic                       penable,
   output logic                       pwrite,
   output logic [31:0]                pwdata,
   input  logic                       pready,
   input  logic                       timer_irq
);

   localparam int unsigned IDX_W = $clog2(N_SLOTS);

   state_e                   r_state, w_state_nxt;
   logic                     r_acc, w_acc_nxt;
   logic [SETTLE_W-1:0]      r_settle, w_settle_nxt;
   logic                     r_dirty, w_dirty_nxt;
   logic [DL_W-1:0]          r_cmp, w_cmp_nxt;
   logic [N_SLOTS-1:0]       r_armed;
   logic [N_SLOTS-1:0][DL_W-1:0] r_deadline;
   logic [N_SLOTS-1:0]       r_fire, w_fire_nxt;
   logic                     r_busy, w_busy_nxt;
   logic                     r_psel, w_psel_nxt;
   logic                     r_penable, w_penable_nxt;
   apb_wr_t                  r_wr, w_wr_nxt;
   logic [DL_W-1:0]          w_target;
   logic                     w_none_armed;
   logic                     w_store_chg;
   logic [N_SLOTS-1:0]       w_wen_mask;
   logic [N_SLOTS-1:0]       w_clr_mask;

   hazard3_timer_sched_min #(.N_SLOTS(N_SLOTS)) u_min (
      .i_armed        (r_armed),
      .i_deadline     (r_deadline),
      .o_min_c        (w_target),
      .o_none_armed_c (w_none_armed)
   );

   assign w_store_chg = slot_wen | slot_clr;

   always_comb begin
      w_wen_mask = '0;
      w_clr_mask = '0;
      for (int unsigned i = 0; i < N_SLOTS; i++) begin
         w_wen_mask[i] = slot_wen && (slot_idx == IDX_W'(i));
         w_clr_mask[i] = slot_clr && !slot_wen && (slot_idx == IDX_W'(i));
      end
   end

   // Slot store: a write always wins over clear and over expiry disarm.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_armed    <= '0;
         r_deadline <= '0;
      end else begin
         for (int unsigned i = 0; i < N_SLOTS; i++) begin
            if (w_wen_mask[i]) begin
               r_armed[i]    <= 1'b1;
               r_deadline[i] <= slot_deadline;
            end else if (w_clr_mask[i]) begin
               r_armed[i]    <= 1'b0;
            end else if ((r_state == ST_EXPIRE) && r_fire[i]) begin
               r_armed[i]    <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_RESET_PROG;
         r_acc     <= 1'b0;
         r_settle  <= '0;
         r_dirty   <= 1'b1;
         r_cmp     <= CMP_DISABLE;
         r_fire    <= '0;
         r_busy    <= 1'b0;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_wr      <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_acc     <= w_acc_nxt;
         r_settle  <= w_settle_nxt;
         r_dirty   <= w_dirty_nxt;
         r_cmp     <= w_cmp_nxt;
         r_fire    <= w_fire_nxt;
         r_busy    <= w_busy_nxt;
         r_psel    <= w_psel_nxt;
         r_penable <= w_penable_nxt;
         r_wr      <= w_wr_nxt;
      end
   end

   // Next state; APB and status outputs are registered from the next state.
   always_comb begin
      w_state_nxt  = r_state;
      w_acc_nxt    = r_acc;
      w_settle_nxt = r_settle;
      w_dirty_nxt  = r_dirty | w_store_chg;
      w_cmp_nxt    = r_cmp;
      w_fire_nxt   = '0;
      w_wr_nxt     = '0;

      case (r_state)
         ST_RESET_PROG, ST_CALC: begin
            w_cmp_nxt   = w_target;
            w_dirty_nxt = w_store_chg;
            w_acc_nxt   = 1'b0;
            w_state_nxt = ST_WR_LO_MAX;
         end
         ST_WR_LO_MAX, ST_WR_HI, ST_WR_LO: begin
            if (!r_acc) begin
               w_acc_nxt = 1'b1;
            end else if (pready) begin
               w_acc_nxt    = 1'b0;
               w_settle_nxt = '0;
               case (r_state)
                  ST_WR_LO_MAX: w_state_nxt = ST_WR_HI;
                  ST_WR_HI:     w_state_nxt = ST_WR_LO;
                  default:      w_state_nxt = ST_SETTLE;
               endcase
            end
         end
         ST_SETTLE: begin
            if (r_settle == SETTLE_W'(SETTLE_LEN - 1)) begin
               w_state_nxt = (r_dirty || w_store_chg) ? ST_CALC : ST_WAIT;
            end else begin
               w_settle_nxt = r_settle + SETTLE_W'(1);
            end
         end
         ST_WAIT: begin
            if (timer_irq && !w_none_armed) begin
               w_state_nxt = ST_EXPIRE;
               for (int unsigned i = 0; i < N_SLOTS; i++) begin
                  w_fire_nxt[i] = r_armed[i] && (r_deadline[i] <= r_cmp) && !w_wen_mask[i];
               end
            end else if (r_dirty || w_store_chg) begin
               w_state_nxt = ST_CALC;
            end
         end
         ST_EXPIRE: w_state_nxt = ST_CALC;
         default:   w_state_nxt = ST_RESET_PROG;
      endcase

      w_busy_nxt    = (w_state_nxt != ST_WAIT) && (w_state_nxt != ST_EXPIRE) &&
                      (w_state_nxt != ST_RESET_PROG);
      w_psel_nxt    = (w_state_nxt == ST_WR_LO_MAX) || (w_state_nxt == ST_WR_HI) ||
                      (w_state_nxt == ST_WR_LO);
      w_penable_nxt = w_psel_nxt && w_acc_nxt;

      case (w_state_nxt)
         ST_WR_LO_MAX: w_wr_nxt = '{addr: CMP_LO_ADDR, data: CMP_DISABLE[31:0]};
         ST_WR_HI:     w_wr_nxt = '{addr: CMP_HI_ADDR, data: r_cmp[63:32]};
         ST_WR_LO:     w_wr_nxt = '{addr: CMP_LO_ADDR, data: r_cmp[31:0]};
         default:      w_wr_nxt = '0;
      endcase
   end

   assign armed   = r_armed;
   assign fire    = r_fire;
   assign busy    = r_busy;
   assign psel    = r_psel;
   assign penable = r_penable;
   assign pwrite  = r_psel;
   assign paddr   = r_wr.addr;
   assign pwdata  = r_wr.data;

endmodule

// File: tb/tb_hazard3_timer_sched.sv
// Directed bench for hazard3_timer_sched with a small APB mtime/mtimecmp timer model.
module tb_hazard3_timer_sched;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        slot_wen, slot_clr;
   logic [1:0]  slot_idx;
   logic [63:0] slot_deadline;
   logic [3:0]  armed, fire;
   logic        busy, psel, penable, pwrite, pready, timer_irq;
   logic [15:0] paddr;
   logic [31:0] pwdata;

   logic [63:0] mtime, mtimecmp, mt_load_val;
   logic        mt_run, mt_load, stall_set;
   logic [1:0]  stall_cnt;
   logic [47:0] wlog[$];
   logic [47:0] setup_q;
   int          fire_cnt = 0;
   int          stab_viol = 0;
   int          checks = 0;
   int          errors = 0;

   hazard3_timer_sched dut (
      .clk(clk), .rst_n(rst_n), .slot_wen(slot_wen), .slot_clr(slot_clr),
      .slot_idx(slot_idx), .slot_deadline(slot_deadline), .armed(armed), .fire(fire),
      .busy(busy), .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
      .pwdata(pwdata), .pready(pready), .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   // Timer model: mtimecmp resets to 0, so the interrupt is high out of reset.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtime     <= '0;
         mtimecmp  <= '0;
         stall_cnt <= '0;
      end else begin
         if (mt_load) mtime <= mt_load_val;
         else if (mt_run) mtime <= mtime + 64'd1;
         if (psel && penable && pready && pwrite) begin
            if (paddr == 16'h0010) mtimecmp[31:0] <= pwdata;
            else if (paddr == 16'h0014) mtimecmp[63:32] <= pwdata;
         end
         if (stall_set) stall_cnt <= 2'd3;
         else if (psel && penable && (paddr == 16'h0014) && (stall_cnt != 2'd0))
            stall_cnt <= stall_cnt - 2'd1;
      end
   end

   assign pready    = !(psel && penable && (paddr == 16'h0014) && (stall_cnt != 2'd0));
   assign timer_irq = (mtime >= mtimecmp);

   always @(posedge clk) begin
      if (psel && penable && pready) wlog.push_back({paddr, pwdata});
      if (fire != 4'd0) fire_cnt <= fire_cnt + $countones(fire);
      if (psel && !pwrite) stab_viol <= stab_viol + 1;
      if (psel && !penable) setup_q <= {paddr, pwdata};
      else if (psel && penable && ({paddr, pwdata} != setup_q)) stab_viol <= stab_viol + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] wr(input logic [15:0] a, input logic [31:0] d);
      return 64'({a, d});
   endfunction

   task automatic arm(input int idx, input logic [63:0] dl);
      slot_idx = 2'(idx); slot_deadline = dl; slot_wen = 1'b1;
      @(negedge clk);
      slot_wen = 1'b0;
   endtask

   task automatic clr(input int idx);
      slot_idx = 2'(idx); slot_clr = 1'b1;
      @(negedge clk);
      slot_clr = 1'b0;
   endtask

   task automatic wait_idle(input int max, output int cyc);
      cyc = 0;
      while (busy && cyc < max) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic wait_fire(input int max, output logic [3:0] f);
      int cyc = 0;
      while ((fire == 4'd0) && cyc < max) begin
         @(negedge clk);
         cyc++;
      end
      f = fire;
   endtask

   initial begin
      int          cyc, cyc2, base, fc;
      logic [3:0]  f;
      rst_n = 1'b0; slot_wen = 1'b0; slot_clr = 1'b0; slot_idx = '0; slot_deadline = '0;
      mt_run = 1'b0; mt_load = 1'b0; mt_load_val = '0; stall_set = 1'b0;
      repeat (2) @(negedge clk);

      // Reset values
      chk("rst_armed", 64'(armed), 64'h0);
      chk("rst_fire", 64'(fire), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_apb_ctl", 64'({psel, penable, pwrite}), 64'h0);
      chk("rst_paddr", 64'(paddr), 64'h0);
      chk("rst_pwdata", 64'(pwdata), 64'h0);

      // Reset programming sequence with the interrupt initially high
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_first_setup", 64'({busy, psel, penable, paddr, pwdata}),
          64'({1'b1, 1'b1, 1'b0, 16'h0010, 32'hFFFF_FFFF}));
      wait_idle(40, cyc);
      chk("rst_seq_len", 64'(cyc), 64'd8);
      chk("rst_wr_count", 64'(wlog.size()), 64'd3);
      chk("rst_wr0", 64'(wlog[0]), wr(16'h0010, 32'hFFFF_FFFF));
      chk("rst_wr1", 64'(wlog[1]), wr(16'h0014, 32'hFFFF_FFFF));
      chk("rst_wr2", 64'(wlog[2]), wr(16'h0010, 32'hFFFF_FFFF));
      chk("rst_nofire", 64'(fire_cnt), 64'd0);
      chk("rst_cmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);

      // Arm slot 2, then an earlier slot 0 while busy: second sequence follows
      base = wlog.size();
      arm(2, 64'h0000_0001_0000_0010);
      @(negedge clk);
      @(negedge clk);
      arm(0, 64'h0000_0000_0000_0100);
      wait_idle(60, cyc);
      chk("t2_len", 64'(cyc), 64'd15);
      chk("t2_wr_count", 64'(wlog.size() - base), 64'd6);
      chk("t2_wr_hi1", 64'(wlog[base+1]), wr(16'h0014, 32'h0000_0001));
      chk("t2_wr_lo1", 64'(wlog[base+2]), wr(16'h0010, 32'h0000_0010));
      chk("t2_wr_max2", 64'(wlog[base+3]), wr(16'h0010, 32'hFFFF_FFFF));
      chk("t2_wr_hi2", 64'(wlog[base+4]), wr(16'h0014, 32'h0000_0000));
      chk("t2_wr_lo2", 64'(wlog[base+5]), wr(16'h0010, 32'h0000_0100));
      chk("t2_cmp", mtimecmp, 64'h100);
      chk("t2_armed", 64'(armed), 64'b0101);

      // Expiry with mtime running: slots 0,1 at 0x100, slot 3 at 0x200
      clr(2);
      arm(1, 64'h100);
      arm(3, 64'h200);
      wait_idle(80, cyc);
      chk("t3_idle", 64'(busy), 64'd0);
      chk("t3_cmp", mtimecmp, 64'h100);
      chk("t3_armed", 64'(armed), 64'b1011);
      mt_load_val = 64'hF0; mt_load = 1'b1;
      @(negedge clk);
      mt_load = 1'b0; mt_run = 1'b1;
      wait_fire(100, f);
      chk("t3_fire1", 64'(f), 64'b0011);
      @(negedge clk);
      chk("t3_fire1_pulse", 64'(fire), 64'b0000);
      chk("t3_fire1_cnt", 64'(fire_cnt), 64'd2);
      wait_idle(40, cyc);
      chk("t3_armed2", 64'(armed), 64'b1000);
      chk("t3_cmp2", mtimecmp, 64'h200);
      wait_fire(400, f);
      chk("t3_fire2", 64'(f), 64'b1000);
      @(negedge clk);
      wait_idle(40, cyc);
      mt_run = 1'b0;
      chk("t3_armed3", 64'(armed), 64'b0000);
      chk("t3_cmp3", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t3_fire_total", 64'(fire_cnt), 64'd3);

      // pready held low for 3 cycles on the high-word write
      stall_set = 1'b1;
      @(negedge clk);
      stall_set = 1'b0;
      base = wlog.size();
      arm(2, 64'h0000_0003_0000_0040);
      cyc = 0;
      while (pready && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      chk("t4_stall_hold", 64'({psel, penable, paddr, pwdata}),
          64'({1'b1, 1'b1, 16'h0014, 32'h0000_0003}));
      @(negedge clk);
      chk("t4_stall_hold2", 64'({pready, paddr, pwdata}), 64'({1'b0, 16'h0014, 32'h0000_0003}));
      wait_idle(40, cyc2);
      chk("t4_len", 64'(cyc + 1 + cyc2), 64'd12);
      chk("t4_wr_hi", 64'(wlog[base+1]), wr(16'h0014, 32'h0000_0003));
      chk("t4_wr_lo", 64'(wlog[base+2]), wr(16'h0010, 32'h0000_0040));
      chk("t4_stable", 64'(stab_viol), 64'd0);
      chk("t4_cmp", mtimecmp, 64'h0000_0003_0000_0040);

      // Rewrite of an expiring slot on the edge into EXPIRE: write wins, no fire
      mt_load_val = 64'h2F0; mt_load = 1'b1;
      @(negedge clk);
      mt_load = 1'b0;
      clr(2);
      arm(0, 64'h300);
      wait_idle(80, cyc);
      chk("t5_cmp", mtimecmp, 64'h300);
      chk("t5_armed", 64'(armed), 64'b0001);
      fc = fire_cnt;
      mt_load_val = 64'h300; mt_load = 1'b1;
      @(negedge clk);
      mt_load = 1'b0;
      chk("t5_wait_irq", 64'({busy, timer_irq}), 64'b01);
      arm(0, 64'h500);
      chk("t5_no_fire", 64'(fire), 64'b0000);
      @(negedge clk);
      wait_idle(40, cyc);
      chk("t5_armed2", 64'(armed), 64'b0001);
      chk("t5_cmp2", mtimecmp, 64'h500);
      chk("t5_fire_cnt", 64'(fire_cnt), 64'(fc));

      // Clear the only armed slot in WAIT: back to all-ones, no fire
      clr(0);
      wait_idle(40, cyc);
      chk("t6_len", 64'(cyc), 64'd9);
      chk("t6_armed", 64'(armed), 64'b0000);
      chk("t6_cmp", mtimecmp, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t6_fire_cnt", 64'(fire_cnt), 64'(fc));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
